// File: rtl/multi_phase_intersection_pkg.sv
// Shared types and constants for the N-phase intersection controller.
// Holds the state encoding, lamp masks and default timing values.
package multi_phase_intersection_pkg;

    typedef enum logic [2:0] {
        ALL_RED,
        GREEN,
        YELLOW,
        CLEAR,
        FLASH
    } state_e;

    // Lamp triple ordering is {red, ylw, grn}
    localparam logic [2:0] RED_MSK = 3'b100;
    localparam logic [2:0] YLW_MSK = 3'b010;
    localparam logic [2:0] GRN_MSK = 3'b001;

    localparam int DEF_NUM_PHASES = 4;
    localparam int DEF_PRESCALE   = 4194304;
    localparam int DEF_GRN_TON    = 20;
    localparam int DEF_YLW_TON    = 3;
    localparam int DEF_RED_TON    = 2;
    localparam int DEF_EXT_TON    = 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/multi_phase_intersection_if.sv
// Control and lamp bundle between the board top and the intersection controller.
interface multi_phase_intersection_if
    import multi_phase_intersection_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES
);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

    logic                  flash_en;
    logic [NUM_PHASES-1:0] ped_req;
    logic [NUM_PHASES-1:0] red;
    logic [NUM_PHASES-1:0] ylw;
    logic [NUM_PHASES-1:0] grn;
    logic [NUM_PHASES-1:0] walk;
    logic [PW-1:0]         phase;

    modport master (
        output flash_en, ped_req,
        input  red, ylw, grn, walk, phase
    );

    modport slave (
        input  flash_en, ped_req,
        output red, ylw, grn, walk, phase
    );

endinterface

// File: rtl/multi_phase_intersection_tick_prescaler.sv
// Divides the board clock into a one-clk tick every PRESCALE cycles.
// Reset is asynchronous and active-high despite the port name.
module tick_prescaler
    import multi_phase_intersection_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_count <= '0;
        end else if (r_count == LAST) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign tick = (r_count == LAST);

endmodule

// File: rtl/multi_phase_intersection.sv
// Round-robin N-phase traffic controller with per-phase pedestrian extension
// and a flash mode; all lamp outputs are registered.
module multi_phase_intersection
    import multi_phase_intersection_pkg::*;
#(
    parameter int NUM_PHASES = DEF_NUM_PHASES,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int GRN_TON    = DEF_GRN_TON,
    parameter int YLW_TON    = DEF_YLW_TON,
    parameter int RED_TON    = DEF_RED_TON,
    parameter int EXT_TON    = DEF_EXT_TON
) (
    input  logic clk,
    input  logic reset_n,
    multi_phase_intersection_if.slave bus
);
    localparam int PW = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;
    localparam int TW = $clog2(max3(GRN_TON + EXT_TON, YLW_TON, RED_TON) + 1);

    localparam logic [TW-1:0]         T_GRN_END  = TW'(GRN_TON - 1);
    localparam logic [TW-1:0]         T_EXT_END  = TW'(GRN_TON + EXT_TON - 1);
    localparam logic [TW-1:0]         T_YLW_END  = TW'(YLW_TON - 1);
    localparam logic [TW-1:0]         T_RED_END  = TW'(RED_TON - 1);
    localparam logic [PW-1:0]         LAST_PHASE = PW'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] ONE        = NUM_PHASES'(1);

    state_e                r_state, w_state_nxt;
    logic [TW-1:0]         r_timer, w_timer_nxt;
    logic [PW-1:0]         r_phase, w_phase_nxt;
    logic [NUM_PHASES-1:0] r_pend, w_pend_nxt, w_pend_clr;
    logic                  r_ext_used, w_ext_used_nxt;
    logic                  r_flash_on, w_flash_on_nxt;
    logic [NUM_PHASES-1:0] r_red, r_ylw, r_grn, r_walk;
    logic [NUM_PHASES-1:0] w_red_nxt, w_ylw_nxt, w_grn_nxt, w_walk_nxt;
    logic [NUM_PHASES-1:0] w_sel, w_sel_nxt;
    logic                  w_tick;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_sel     = ONE << r_phase;
    assign w_sel_nxt = ONE << w_phase_nxt;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state    <= ALL_RED;
            r_timer    <= '0;
            r_phase    <= '0;
            r_pend     <= '0;
            r_ext_used <= 1'b0;
            r_flash_on <= 1'b0;
            r_red      <= '1;
            r_ylw      <= '0;
            r_grn      <= '0;
            r_walk     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_phase    <= w_phase_nxt;
            r_pend     <= w_pend_nxt;
            r_ext_used <= w_ext_used_nxt;
            r_flash_on <= w_flash_on_nxt;
            r_red      <= w_red_nxt;
            r_ylw      <= w_ylw_nxt;
            r_grn      <= w_grn_nxt;
            r_walk     <= w_walk_nxt;
        end
    end

    // A nonzero walk register marks that the served phase is in its extension
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_phase_nxt    = r_phase;
        w_ext_used_nxt = r_ext_used;
        w_flash_on_nxt = r_flash_on;
        w_walk_nxt     = r_walk;
        w_pend_clr     = '0;
        if (w_tick) begin
            w_timer_nxt = r_timer + TW'(1);
            if (bus.flash_en) begin
                w_timer_nxt = '0;
                w_walk_nxt  = '0;
                if (r_state == FLASH) begin
                    w_flash_on_nxt = ~r_flash_on;
                end else begin
                    w_state_nxt    = FLASH;
                    w_flash_on_nxt = 1'b1;
                end
            end else begin
                unique case (r_state)
                    ALL_RED: begin
                        if (r_timer == T_RED_END) begin
                            w_state_nxt = GREEN;
                            w_timer_nxt = '0;
                            w_phase_nxt = '0;
                        end
                    end
                    GREEN: begin
                        if (|r_walk) begin
                            if (r_timer == T_EXT_END) begin
                                w_state_nxt = YELLOW;
                                w_timer_nxt = '0;
                                w_walk_nxt  = '0;
                            end
                        end else if (r_timer == T_GRN_END) begin
                            if ((|(r_pend & w_sel)) && !r_ext_used) begin
                                w_ext_used_nxt = 1'b1;
                                w_pend_clr     = w_sel;
                                w_walk_nxt     = w_sel;
                            end else begin
                                w_state_nxt = YELLOW;
                                w_timer_nxt = '0;
                            end
                        end
                    end
                    YELLOW: begin
                        if (r_timer == T_YLW_END) begin
                            w_state_nxt = CLEAR;
                            w_timer_nxt = '0;
                        end
                    end
                    CLEAR: begin
                        if (r_timer == T_RED_END) begin
                            w_state_nxt    = GREEN;
                            w_timer_nxt    = '0;
                            w_ext_used_nxt = 1'b0;
                            w_phase_nxt    = (r_phase == LAST_PHASE) ? '0 : r_phase + PW'(1);
                        end
                    end
                    FLASH: begin
                        w_state_nxt    = ALL_RED;
                        w_timer_nxt    = '0;
                        w_phase_nxt    = '0;
                        w_ext_used_nxt = 1'b0;
                        w_flash_on_nxt = 1'b0;
                    end
                    default: begin
                        w_state_nxt = ALL_RED;
                        w_timer_nxt = '0;
                    end
                endcase
            end
        end
    end

    // New requests win over a same-edge clear so none are lost
    assign w_pend_nxt = (r_pend & ~w_pend_clr) | bus.ped_req;

    always_comb begin
        w_red_nxt = '1;
        w_ylw_nxt = '0;
        w_grn_nxt = '0;
        unique case (w_state_nxt)
            GREEN: begin
                w_grn_nxt = w_sel_nxt;
                w_red_nxt = ~w_sel_nxt;
            end
            YELLOW: begin
                w_ylw_nxt = w_sel_nxt;
                w_red_nxt = ~w_sel_nxt;
            end
            FLASH: begin
                w_ylw_nxt = w_flash_on_nxt ? ONE  : '0;
                w_red_nxt = w_flash_on_nxt ? ~ONE : '0;
            end
            default: begin
                w_red_nxt = '1;
            end
        endcase
    end

    assign bus.red   = r_red;
    assign bus.ylw   = r_ylw;
    assign bus.grn   = r_grn;
    assign bus.walk  = r_walk;
    assign bus.phase = r_phase;

endmodule

// File: tb/tb_multi_phase_intersection.sv
// Directed bench for multi_phase_intersection with 3 phases and PRESCALE=4,
// sampling lamps on the falling edge inside each tick slot.
module tb_multi_phase_intersection;

    localparam int N = 3;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    multi_phase_intersection_if #(.NUM_PHASES(N)) bus ();

    multi_phase_intersection #(
        .NUM_PHASES (N),
        .PRESCALE   (4),
        .GRN_TON    (5),
        .YLW_TON    (2),
        .RED_TON    (1),
        .EXT_TON    (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic waitCyc(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Slot k is the k-th tick period after reset release; cycle 4k lies inside it
    task automatic goSlot(input int s);
        waitCyc(4 * s);
    endtask

    task automatic applyStimulus(input logic [N-1:0] req, input logic flash);
        bus.ped_req  = req;
        bus.flash_en = flash;
    endtask

    task automatic pulseReq(input logic [N-1:0] req);
        applyStimulus(req, 1'b0);
        waitCyc(cyc + 1);
        applyStimulus('0, 1'b0);
    endtask

    task automatic checkLamps(input string tag, input logic [N-1:0] eRed,
                              input logic [N-1:0] eYlw, input logic [N-1:0] eGrn,
                              input logic [N-1:0] eWalk);
        checks++;
        assert (bus.red === eRed) else begin
            errors++;
            $error("[TB] FAIL %s red observed=%b expected=%b", tag, bus.red, eRed);
        end
        checks++;
        assert (bus.ylw === eYlw) else begin
            errors++;
            $error("[TB] FAIL %s ylw observed=%b expected=%b", tag, bus.ylw, eYlw);
        end
        checks++;
        assert (bus.grn === eGrn) else begin
            errors++;
            $error("[TB] FAIL %s grn observed=%b expected=%b", tag, bus.grn, eGrn);
        end
        checks++;
        assert (bus.walk === eWalk) else begin
            errors++;
            $error("[TB] FAIL %s walk observed=%b expected=%b", tag, bus.walk, eWalk);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] eRed,
                               input logic [N-1:0] eYlw, input logic [N-1:0] eGrn,
                               input logic [N-1:0] eWalk, input logic [1:0] ePhase);
        checkLamps(tag, eRed, eYlw, eGrn, eWalk);
        checks++;
        assert (bus.phase === ePhase) else begin
            errors++;
            $error("[TB] FAIL %s phase observed=%0d expected=%0d", tag, bus.phase, ePhase);
        end
    endtask

    task automatic doReset();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        cyc     = 0;
    endtask

    initial begin
        applyStimulus('0, 1'b0);
        $display("[TB] reset and plain cycling");
        doReset();
        checkOutput("rst",        3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        goSlot(1);   checkOutput("p0_grn",     3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        goSlot(5);   checkOutput("p0_grn_end", 3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        goSlot(6);   checkOutput("p0_ylw",     3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        goSlot(8);   checkOutput("p0_clr",     3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        goSlot(9);   checkOutput("p1_grn",     3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        goSlot(17);  checkOutput("p2_grn",     3'b011, 3'b000, 3'b100, 3'b000, 2'd2);
        goSlot(25);  checkOutput("wrap_p0",    3'b110, 3'b000, 3'b001, 3'b000, 2'd0);

        $display("[TB] pedestrian extension on phase 1");
        pulseReq(3'b010);
        goSlot(37);  checkOutput("p1_base_end", 3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        goSlot(38);  checkOutput("p1_ext_beg",  3'b101, 3'b000, 3'b010, 3'b010, 2'd1);
        goSlot(40);  checkOutput("p1_ext_end",  3'b101, 3'b000, 3'b010, 3'b010, 2'd1);
        goSlot(41);  checkOutput("p1_ext_ylw",  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        goSlot(48);  checkOutput("p2_noext",    3'b011, 3'b000, 3'b100, 3'b000, 2'd2);
        goSlot(49);  checkOutput("p2_ylw",      3'b011, 3'b100, 3'b000, 3'b000, 2'd2);

        $display("[TB] late request during extension");
        goSlot(52);  checkOutput("p0_grn2",     3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        pulseReq(3'b001);
        goSlot(57);  checkOutput("p0_ext",      3'b110, 3'b000, 3'b001, 3'b001, 2'd0);
        goSlot(58);  pulseReq(3'b001);
        goSlot(60);  checkOutput("p0_no2nd",    3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        goSlot(67);  checkOutput("p1_plain",    3'b101, 3'b000, 3'b010, 3'b000, 2'd1);
        goSlot(68);  checkOutput("p1_ylw",      3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        goSlot(84);  checkOutput("p0_held_ext", 3'b110, 3'b000, 3'b001, 3'b001, 2'd0);
        goSlot(87);  checkOutput("p0_ylw3",     3'b110, 3'b001, 3'b000, 3'b000, 2'd0);

        $display("[TB] simultaneous requests");
        goSlot(88);  pulseReq(3'b111);
        goSlot(95);  checkOutput("all_p1_ext",  3'b101, 3'b000, 3'b010, 3'b010, 2'd1);
        goSlot(98);  checkOutput("all_p1_ylw",  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);
        goSlot(106); checkOutput("all_p2_ext",  3'b011, 3'b000, 3'b100, 3'b100, 2'd2);
        goSlot(117); checkOutput("all_p0_ext",  3'b110, 3'b000, 3'b001, 3'b001, 2'd0);
        goSlot(120); checkOutput("all_p0_ylw",  3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        goSlot(128); checkOutput("pend_empty",  3'b101, 3'b010, 3'b000, 3'b000, 2'd1);

        $display("[TB] flash mode");
        waitCyc(4 * 128 + 1);
        applyStimulus('0, 1'b1);
        goSlot(129); checkLamps("flash_lit",    3'b110, 3'b001, 3'b000, 3'b000);
        goSlot(130); checkLamps("flash_dark",   3'b000, 3'b000, 3'b000, 3'b000);
        goSlot(131); checkLamps("flash_lit2",   3'b110, 3'b001, 3'b000, 3'b000);
        waitCyc(4 * 131 + 1);
        applyStimulus('0, 1'b0);
        goSlot(132); checkOutput("flash_exit",  3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        goSlot(133); checkOutput("resume_p0",   3'b110, 3'b000, 3'b001, 3'b000, 2'd0);

        $display("[TB] asynchronous reset mid-extension");
        pulseReq(3'b001);
        goSlot(138); checkOutput("pre_rst_ext", 3'b110, 3'b000, 3'b001, 3'b001, 2'd0);
        goSlot(139);
        #2 reset_n = 1'b1;
        #1 checkOutput("async_rst",   3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        cyc     = 0;
        checkOutput("rst2",           3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        goSlot(1);   checkOutput("rst2_p0_grn", 3'b110, 3'b000, 3'b001, 3'b000, 2'd0);
        goSlot(6);   checkOutput("rst2_p0_ylw", 3'b110, 3'b001, 3'b000, 3'b000, 2'd0);
        goSlot(8);   checkOutput("rst2_clr",    3'b111, 3'b000, 3'b000, 3'b000, 2'd0);
        goSlot(9);   checkOutput("rst2_p1_grn", 3'b101, 3'b000, 3'b010, 3'b000, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_phase_intersection.md
# multi_phase_intersection

Parametrised N-phase traffic-light controller, the successor of the fixed two-way intersection block. It sequences NUM_PHASES approach phases round-robin through green, yellow and all-red clearance, with all timing counted in prescaled ticks. Pedestrian requests are latched per phase and each earns a single green extension with a walk indication. A flash mode puts the intersection into flashing yellow/red for fault or maintenance. It sits directly below the board top, driving the lamp outputs from the board clock.

## Interface
- NUM_PHASES, 4, number of phases, legal range 2..8
- PRESCALE, 4194304, clk cycles per tick, must be ≥ 1
- GRN_TON, 20, base green duration in ticks, ≥ 1
- YLW_TON, 3, yellow duration in ticks, ≥ 1
- RED_TON, 2, all-red clearance in ticks, ≥ 1
- EXT_TON, 10, pedestrian green extension in ticks, ≥ 1
- clk  in  1  single clock, rising edge
- reset_n  in  1  reset, asynchronous and active-high (despite the name)
- flash_en  in  1  level; request flash mode
- ped_req  in  NUM_PHASES  per-phase crosswalk request; a one-clk pulse is sufficient
- red  out  NUM_PHASES  red lamp per phase
- ylw  out  NUM_PHASES  yellow lamp per phase
- grn  out  NUM_PHASES  green lamp per phase
- walk  out  NUM_PHASES  walk lamp per phase
- phase  out  $clog2(NUM_PHASES)  index of the phase currently served

## Operation
- Reset state:
  - state ALL_RED, phase=0, timer=0, prescaler=0.
  - Pending requests ped_pend=0; extension flag ext_used=0.
  - Outputs: red all ones, ylw/grn/walk all zero, phase 0.
- States: ALL_RED (start-up), GREEN, YELLOW, CLEAR, FLASH.
- Transitions are evaluated only on tick cycles. The timer counts ticks spent in the current state and is zeroed on every state change.
- ALL_RED: after RED_TON ticks go to GREEN with phase=0.
- GREEN:
  - At the tick where timer reaches GRN_TON-1: if ped_pend[phase] is set and ext_used=0, set ext_used, clear ped_pend[phase], assert walk[phase], and stay in GREEN for EXT_TON further ticks. Otherwise go to YELLOW.
  - At the end of the extension, deassert walk and go to YELLOW.
- YELLOW: after YLW_TON ticks go to CLEAR.
- CLEAR:
  - After RED_TON ticks, set phase=(phase+1) mod NUM_PHASES, clear ext_used, and go to GREEN.
  - Phase NUM_PHASES-1 wraps to 0.
- Lamp mapping:
  - The served phase shows GREEN/YELLOW per state; all other phases show red.
  - In ALL_RED and CLEAR every phase shows red.
  - Exactly one of red/ylw/grn is high per phase, except in FLASH.
- ped_req latching:
  - ped_req[i] sets ped_pend[i] on any clk edge, independent of tick.
  - A request for the served phase arriving after the extension decision, or during its extension, is held for that phase's next green.
  - A set that coincides with a clear on the same edge is retained (set wins).
- FLASH:
  - flash_en is sampled on tick. When high, go to FLASH from any state and zero the timer.
  - walk is all zero and ped_pend is preserved.
  - Phase 0 ylw and all other phases' red toggle every tick, starting lit.
  - When flash_en is sampled low, go to ALL_RED with phase=0 and clear ext_used; normal sequencing then resumes.
- Reset mid-operation asynchronously forces the reset state on any clk phase.

## Timing
- Tick: the prescaler counts 0..PRESCALE-1. An internal tick pulse is high for one clk when the count equals PRESCALE-1. With PRESCALE=1, tick is high every cycle.
- Lamps, walk and phase are registered and change on the same clk edge as the state transition, with zero extra latency.
- One phase without extension: GRN_TON+YLW_TON+RED_TON ticks. With extension, add EXT_TON.
- Timer width: $clog2(max(GRN_TON+EXT_TON, YLW_TON, RED_TON)+1). The timer never wraps.
- ped_req to ped_pend latency: 1 clk.

## Structure
- Shared package:
  - State enum (ALL_RED, GREEN, YELLOW, CLEAR, FLASH).
  - Lamp mask constants RED_MSK/YLW_MSK/GRN_MSK.
  - Default timing constants.
- Sub-module tick_prescaler: parameter PRESCALE; ports clk, reset_n, tick. Reusable by other light blocks.

## Test plan
All scenarios use NUM_PHASES=3, PRESCALE=4, GRN_TON=5, YLW_TON=2, RED_TON=1, EXT_TON=3.
- Reset and plain cycling:
  - Release reset → red=3'b111 for 1 tick.
  - Then grn[0] for 5 ticks, ylw[0] for 2 ticks, all red for 1 tick, then grn[1].
  - phase goes 0→1→2→0. A full rotation takes 24 ticks = 96 clk.
- Extension: a 1-clk ped_req[1] pulse during phase 0 green → phase 1 green lasts 8 ticks, and walk[1] is high for the last 3. Phase 2 is unextended.
- Late request: ped_req[0] during phase 0's extension → no second extension now; phase 0's next green is extended.
- Simultaneous requests: ped_req=3'b111 in one clk → each phase is extended exactly once in the next rotation, and ped_pend reaches 0.
- Flash:
  - flash_en=1 mid-YELLOW of phase 1 → at the next tick, ylw[0] and red[1], red[2] toggle per tick, with grn/walk zero.
  - Drop flash_en → 1 tick all red, then grn[0].
- Asynchronous reset: reset_n pulse mid-extension, between clk edges → outputs return to the reset values immediately, and the sequence restarts as in the first scenario.
